sha256_padder: RTL and testbench

Byte-stream front end for the SHA-256 compression core. Accepts a message of arbitrary length one byte per cycle, appends the SHA-256 padding (0x80, zero fill, 64-bit big-endian bit length) and delivers complete 512-bit blocks over a valid/ready handshake. Blocks use the core's `[0:511]` message ordering, with bit 0 as the MSB of the first byte. The block sits upstream of the hash core and is the producer of its `message` input.

---
 rtl/sha256_padder_if.sv | 21 ++
 rtl/sha256_padder.sv | 120 ++++++++++++
 tb/tb_sha256_padder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sha256_padder_if.sv
// sha256_padder_if: byte-stream input and 512-bit block output handshakes of the SHA-256 padder
interface sha256_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_empty;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  modport master (
    output in_valid, in_data, in_last, in_empty, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last
  );
  modport slave (
    input  in_valid, in_data, in_last, in_empty, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last
  );
endinterface

// File: rtl/sha256_padder.sv
// sha256_padder: pads a byte stream per SHA-256 and emits 512-bit blocks; optional len_err via SHA256_PADDER_LENCHK_EN
// blk_data[511] is bit 0 of the core's [0:511] message, so byte i lives at blk_data[511-8i -: 8].
module sha256_padder #(
  parameter int LEN_W = 61
) (
  input logic            clk,
  input logic            reset,
  sha256_padder_if.slave pad_if
`ifdef SHA256_PADDER_LENCHK_EN
  ,
  output logic           len_err
`endif
);
  typedef enum logic [1:0] {FILL, PAD, EMIT, EXTRA} state_t;
  state_t           state_q, state_d;
  logic [511:0]     buf_q, buf_d;
  logic [6:0]       ptr_q, ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             first_q, first_d;
  logic             final_q, final_d;
  logic             pend_q, pend_d;
  logic             lead80_q, lead80_d;
  logic [63:0]      len_bits;
  logic [511:0]     keep, mark, padded;
  logic             acc, byte_acc;
  assign len_bits = 64'(len_q) << 3;
  assign acc      = pad_if.in_valid & (state_q == FILL);
  assign byte_acc = acc & ~pad_if.in_empty;
  // Bytes below ptr survive padding; the 0x80 marker lands on byte ptr (nowhere when ptr is 64).
  assign keep     = ~({512{1'b1}} >> {ptr_q, 3'b000});
  assign mark     = {8'h80, 504'b0} >> {ptr_q, 3'b000};
  assign padded   = (buf_q & keep) | mark;
  assign pad_if.in_ready  = (state_q == FILL) & ~reset;
  assign pad_if.blk_valid = state_q == EMIT;
  assign pad_if.blk_data  = buf_q;
  assign pad_if.blk_first = first_q;
  assign pad_if.blk_last  = final_q;
  // Next-state logic: byte capture, padding, block hand-off and the owed length-only block.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    first_d  = first_q;
    final_d  = final_q;
    pend_d   = pend_q;
    lead80_d = lead80_q;
    case (state_q)
      FILL: begin
        if (byte_acc) begin
          buf_d[{~ptr_q[5:0], 3'b000} +: 8] = pad_if.in_data;
          ptr_d = ptr_q + 7'd1;
          len_d = len_q + 1'b1;
        end
        if (acc & pad_if.in_last) begin
          state_d = PAD;
        end else if (byte_acc & (ptr_q == 7'd63)) begin
          state_d = EMIT;
          final_d = 1'b0;
        end
      end
      PAD: begin
        buf_d    = ptr_q <= 7'd55 ? {padded[511:64], len_bits} : padded;
        final_d  = ptr_q <= 7'd55;
        pend_d   = ptr_q > 7'd55;
        lead80_d = ptr_q == 7'd64;
        state_d  = EMIT;
      end
      EMIT: begin
        if (pad_if.blk_ready) begin
          first_d = 1'b0;
          ptr_d   = '0;
          state_d = pend_q ? EXTRA : FILL;
          if (!pend_q && final_q) begin
            len_d   = '0;
            first_d = 1'b1;
          end
        end
      end
      EXTRA: begin
        buf_d   = {lead80_q ? 8'h80 : 8'h00, 440'b0, len_bits};
        pend_d  = 1'b0;
        final_d = 1'b1;
        state_d = EMIT;
      end
    endcase
  end
  // State and datapath registers; reset drops any partial message and owed blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FILL;
      buf_q    <= '0;
      ptr_q    <= '0;
      len_q    <= '0;
      first_q  <= 1'b1;
      final_q  <= 1'b0;
      pend_q   <= 1'b0;
      lead80_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      first_q  <= first_d;
      final_q  <= final_d;
      pend_q   <= pend_d;
      lead80_q <= lead80_d;
    end
  end
`ifdef SHA256_PADDER_LENCHK_EN
  logic len_err_q;
  assign len_err = len_err_q;
  // Sticky overflow flag: raised when a byte arrives with the counter saturated, dropped with the final block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) len_err_q <= 1'b0;
    else if (byte_acc && (&len_q)) len_err_q <= 1'b1;
    else if (pad_if.blk_valid && pad_if.blk_ready && final_q) len_err_q <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: randomized and directed checks of sha256_padder against a queue-based padding model
module tb_sha256_padder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  sha256_padder_if pad_if();
`ifdef SHA256_PADDER_LENCHK_EN
  logic len_err;
`endif
  sha256_padder #(.LEN_W(61)) dut (
    .clk   (clk),
    .reset (reset),
    .pad_if(pad_if)
`ifdef SHA256_PADDER_LENCHK_EN
    ,
    .len_err(len_err)
`endif
  );
  int passed = 0;
  int total = 0;
  bit rdy_force = 1'b1;
  bit rdy_val = 1'b1;
  logic [511:0] rx_data[$];
  logic [511:0] exp_blks[$];
  bit rx_first[$];
  bit rx_last[$];
  task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  initial begin
    pad_if.blk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pad_if.blk_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end
  initial forever begin
    @(negedge clk);
    if (!reset && pad_if.blk_valid && pad_if.blk_ready) begin
      rx_data.push_back(pad_if.blk_data);
      rx_first.push_back(pad_if.blk_first);
      rx_last.push_back(pad_if.blk_last);
    end
  end
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic beat(logic [7:0] d, bit last, bit empty);
    int n = 0;
    pad_if.in_valid = 1'b1;
    pad_if.in_data  = d;
    pad_if.in_last  = last;
    pad_if.in_empty = empty;
    do begin
      @(negedge clk);
      n++;
    end while (!pad_if.in_ready && n < 3000);
    if (!pad_if.in_ready) check("beat_timeout", 512'(pad_if.in_ready), 512'(1));
    @(posedge clk);
    #1;
    pad_if.in_valid = 1'b0;
    pad_if.in_last  = 1'b0;
    pad_if.in_empty = 1'b0;
  endtask
  // term: 0 = last flag on final byte, 1 = trailing empty last beat, 2 = leave message open
  task automatic send(logic [7:0] msg[$], bit gaps, int term);
    for (int i = 0; i < msg.size(); i++) begin
      if (gaps && $urandom_range(0, 7) == 0) beat(8'($urandom), 1'b0, 1'b1);
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      beat(msg[i], term == 0 && i == msg.size() - 1, 1'b0);
    end
    if (term == 1 || (term == 0 && msg.size() == 0)) beat(8'($urandom), 1'b1, 1'b1);
  endtask
  task automatic build_exp(logic [7:0] msg[$]);
    logic [7:0] p[$];
    logic [63:0] bl;
    logic [511:0] b;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    exp_blks.delete();
    for (int j = 0; j < p.size() / 64; j++) begin
      b = '0;
      for (int i = 0; i < 64; i++) b = {b[503:0], p[64*j+i]};
      exp_blks.push_back(b);
    end
  endtask
  task automatic verify(string tag);
    int n = 0;
    while (rx_data.size() < exp_blks.size() && n < 5000) begin
      @(posedge clk);
      n++;
    end
    idle(4);
    check({tag, "_nblk"}, 512'(rx_data.size()), 512'(exp_blks.size()));
    for (int j = 0; j < exp_blks.size() && j < rx_data.size(); j++) begin
      check($sformatf("%s_data%0d", tag, j), rx_data[j], exp_blks[j]);
      check($sformatf("%s_first%0d", tag, j), 512'(rx_first[j]), 512'(j == 0));
      check($sformatf("%s_last%0d", tag, j), 512'(rx_last[j]), 512'(j == exp_blks.size() - 1));
    end
    rx_data.delete();
    rx_first.delete();
    rx_last.delete();
  endtask
  initial begin
    logic [7:0] m[$];
    int bnd[13] = '{0, 1, 54, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128};
    int n;
    pad_if.in_valid = 1'b0;
    pad_if.in_data  = 8'h00;
    pad_if.in_last  = 1'b0;
    pad_if.in_empty = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 512'(pad_if.blk_valid), 512'(0));
    check("rst_last", 512'(pad_if.blk_last), 512'(0));
    check("rst_first", 512'(pad_if.blk_first), 512'(1));
    check("rst_data", pad_if.blk_data, '0);
    check("rst_in_ready", 512'(pad_if.in_ready), 512'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 512'(pad_if.in_ready), 512'(1));
    idle(1);
    m = '{8'h61, 8'h62, 8'h63};
    build_exp(m);
    send(m, 1'b0, 0);
    @(negedge clk);
    check("abc_pad_cycle", 512'(pad_if.blk_valid), 512'(0));
    @(negedge clk);
    check("abc_valid_lat", 512'(pad_if.blk_valid), 512'(1));
    check("abc_const", pad_if.blk_data, {32'h61626380, 416'b0, 64'h18});
    check("abc_first", 512'(pad_if.blk_first), 512'(1));
    check("abc_last", 512'(pad_if.blk_last), 512'(1));
    verify("abc");
    m.delete();
    repeat (55) m.push_back(8'h00);
    build_exp(m);
    check("m55_const", exp_blks[0], {440'b0, 8'h80, 64'h1B8});
    send(m, 1'b0, 0);
    verify("m55");
    m.push_back(8'h00);
    build_exp(m);
    send(m, 1'b0, 0);
    verify("m56");
    m.delete();
    repeat (64) m.push_back(8'($urandom));
    build_exp(m);
    send(m, 1'b0, 2);
    @(negedge clk);
    check("b64_valid_lat", 512'(pad_if.blk_valid), 512'(1));
    idle(1);
    beat(8'h00, 1'b1, 1'b1);
    verify("b64");
    m.delete();
    build_exp(m);
    send(m, 1'b0, 0);
    verify("empty");
    rdy_val = 1'b0;
    m = '{8'h61, 8'h62, 8'h63};
    build_exp(m);
    send(m, 1'b0, 0);
    n = 0;
    while (!pad_if.blk_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_seen", 512'(pad_if.blk_valid), 512'(1));
    repeat (20) begin
      @(negedge clk);
      check("stall_valid", 512'(pad_if.blk_valid), 512'(1));
      check("stall_data", pad_if.blk_data, exp_blks[0]);
      check("stall_in_ready", 512'(pad_if.in_ready), 512'(0));
    end
    rdy_val = 1'b1;
    @(negedge clk);
    check("release_valid", 512'(pad_if.blk_valid), 512'(1));
    @(negedge clk);
    check("release_done", 512'(pad_if.blk_valid), 512'(0));
    check("release_in_ready", 512'(pad_if.in_ready), 512'(1));
    verify("stall");
    m.delete();
    repeat (30) m.push_back(8'($urandom));
    send(m, 1'b0, 2);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", 512'(pad_if.blk_valid), 512'(0));
    check("midrst_in_ready", 512'(pad_if.in_ready), 512'(0));
    check("midrst_first", 512'(pad_if.blk_first), 512'(1));
    @(posedge clk);
    #1 reset = 1'b0;
    m = '{8'h61, 8'h62, 8'h63};
    build_exp(m);
    send(m, 1'b0, 0);
    verify("post_rst");
    rdy_force = 1'b0;
    for (int t = 0; t < 20; t++) begin
      int len = $urandom_range(0, 1) ? bnd[$urandom_range(0, 12)] : $urandom_range(0, 200);
      m.delete();
      repeat (len) m.push_back(8'($urandom));
      build_exp(m);
      send(m, 1'($urandom), $urandom_range(0, 1));
      verify($sformatf("rnd%0d_len%0d", t, len));
    end
    rdy_force = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
